// File: rtl/decode_issue_stage.sv
// RV32 decode/issue stage: register file, WB bypass, load-use bubbles,
// flush and sticky halt, with a registered ID/EX boundary.
package rv32i_pkg;

  typedef enum logic [4:0] {
    INSTR_NOP     = 5'd0,
    INSTR_LUI     = 5'd1,
    INSTR_AUIPC   = 5'd2,
    INSTR_JAL     = 5'd3,
    INSTR_JALR    = 5'd4,
    INSTR_BRANCH  = 5'd5,
    INSTR_LB      = 5'd6,
    INSTR_LH      = 5'd7,
    INSTR_LW      = 5'd8,
    INSTR_LBU     = 5'd9,
    INSTR_LHU     = 5'd10,
    INSTR_STORE   = 5'd11,
    INSTR_OPIMM   = 5'd12,
    INSTR_OP      = 5'd13,
    INSTR_FENCE   = 5'd14,
    INSTR_SYSTEM  = 5'd15,
    INSTR_ILLEGAL = 5'd16
  } rv32i_instr_e;

  typedef struct packed {
    logic         valid;
    rv32i_instr_e instr_type;
    logic [4:0]   rs1_addr;
    logic [4:0]   rs2_addr;
    logic [31:0]  rs1_data;
    logic [31:0]  rs2_data;
    logic [31:0]  imm;
    logic [31:0]  pc;
    logic [4:0]   rd_addr;
    logic         write_en;
  } id_ex_t;

  function automatic logic is_load(rv32i_instr_e t);
    return (t == INSTR_LB) || (t == INSTR_LH) || (t == INSTR_LW) ||
           (t == INSTR_LBU) || (t == INSTR_LHU);
  endfunction

endpackage

module decode
  import rv32i_pkg::*;
(
  input  logic [31:0]  instr,
  output logic [4:0]   rs1,
  output logic [4:0]   rs2,
  output logic [4:0]   rd,
  output logic [31:0]  imm,
  output logic         write_en,
  output logic         stall_if,
  output rv32i_instr_e instr_type
);

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
  logic op_lui, op_auipc, op_jal, op_jalr, op_br;
  logic op_ld, op_st, op_imm, op_reg, op_fence, op_sys;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign rs1 = instr[19:15];
  assign rs2 = instr[24:20];
  assign rd  = instr[11:7];

  assign i_imm = {{20{instr[31]}}, instr[31:20]};
  assign s_imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign b_imm = {{19{instr[31]}}, instr[31], instr[7],
                  instr[30:25], instr[11:8], 1'b0};
  assign u_imm = {instr[31:12], 12'b0};
  assign j_imm = {{11{instr[31]}}, instr[31], instr[19:12],
                  instr[20], instr[30:21], 1'b0};

  assign op_lui   = opc == 7'b0110111;
  assign op_auipc = opc == 7'b0010111;
  assign op_jal   = opc == 7'b1101111;
  assign op_jalr  = opc == 7'b1100111;
  assign op_br    = opc == 7'b1100011;
  assign op_ld    = opc == 7'b0000011;
  assign op_st    = opc == 7'b0100011;
  assign op_imm   = opc == 7'b0010011;
  assign op_reg   = opc == 7'b0110011;
  assign op_fence = opc == 7'b0001111;
  assign op_sys   = opc == 7'b1110011;

  // Illegal encodings and SYSTEM ops both ask fetch to stop.
  always_comb begin
    instr_type = INSTR_ILLEGAL;
    imm        = '0;
    write_en   = 1'b0;
    stall_if   = 1'b1;
    unique case (1'b1)
      op_lui: begin
        instr_type = INSTR_LUI;
        imm = u_imm; write_en = 1'b1; stall_if = 1'b0;
      end
      op_auipc: begin
        instr_type = INSTR_AUIPC;
        imm = u_imm; write_en = 1'b1; stall_if = 1'b0;
      end
      op_jal: begin
        instr_type = INSTR_JAL;
        imm = j_imm; write_en = 1'b1; stall_if = 1'b0;
      end
      op_jalr: begin
        instr_type = INSTR_JALR;
        imm = i_imm; write_en = 1'b1; stall_if = 1'b0;
      end
      op_br: begin
        instr_type = INSTR_BRANCH;
        imm = b_imm; stall_if = 1'b0;
      end
      op_ld: begin
        imm = i_imm;
        unique case (f3)
          3'b000:  instr_type = INSTR_LB;
          3'b001:  instr_type = INSTR_LH;
          3'b010:  instr_type = INSTR_LW;
          3'b100:  instr_type = INSTR_LBU;
          3'b101:  instr_type = INSTR_LHU;
          default: instr_type = INSTR_ILLEGAL;
        endcase
        write_en = instr_type != INSTR_ILLEGAL;
        stall_if = instr_type == INSTR_ILLEGAL;
      end
      op_st: begin
        instr_type = INSTR_STORE;
        imm = s_imm; stall_if = 1'b0;
      end
      op_imm: begin
        instr_type = INSTR_OPIMM;
        imm = i_imm; write_en = 1'b1; stall_if = 1'b0;
      end
      op_reg: begin
        instr_type = INSTR_OP;
        write_en = 1'b1; stall_if = 1'b0;
      end
      op_fence: begin
        instr_type = INSTR_FENCE;
        stall_if = 1'b0;
      end
      op_sys: begin
        instr_type = INSTR_SYSTEM;
        imm = i_imm;
      end
      default: ;
    endcase
  end

endmodule

module decode_issue_stage
  import rv32i_pkg::*;
#(
  parameter int NUM_REGS       = 32,
  parameter bit WB_BYPASS      = 1'b1,
  parameter bit LOAD_USE_STALL = 1'b1,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             if_id_valid,
  output logic             if_id_ready,
  input  logic [31:0]      if_id_instr_data,
  input  logic [31:0]      if_id_pc,
  input  logic             wb_id_wr_en,
  input  logic [4:0]       wb_id_rd_addr,
  input  logic [31:0]      wb_id_rd_data,
  output logic             id_ex_valid,
  input  logic             id_ex_ready,
  output rv32i_instr_e     id_ex_instr_type,
  output logic [4:0]       id_ex_rs1_addr,
  output logic [4:0]       id_ex_rs2_addr,
  output logic [31:0]      id_ex_rs1_data,
  output logic [31:0]      id_ex_rs2_data,
  output logic [31:0]      id_ex_imm,
  output logic [31:0]      id_ex_pc,
  output logic [4:0]       id_ex_rd_addr,
  output logic             id_ex_write_en,
  output logic             halted,
  output logic [CNT_W-1:0] hazard_cnt
);

  localparam int AW = $clog2(NUM_REGS);

  logic [4:0]   d_rs1, d_rs2, d_rd;
  logic [31:0]  d_imm;
  logic         d_we, d_stall;
  rv32i_instr_e d_type;

  logic [31:0]  rf [NUM_REGS];
  logic [31:0]  rs1_val, rs2_val;
  id_ex_t       q;
  logic         hazard, advance, accept;

  decode u_dec (
    .instr      (if_id_instr_data),
    .rs1        (d_rs1),
    .rs2        (d_rs2),
    .rd         (d_rd),
    .imm        (d_imm),
    .write_en   (d_we),
    .stall_if   (d_stall),
    .instr_type (d_type)
  );

  function automatic logic in_rf(logic [4:0] a);
    return (a != 5'd0) && ({1'b0, a} < 6'(NUM_REGS));
  endfunction

  always_comb begin
    rs1_val = '0;
    if (in_rf(d_rs1)) begin
      rs1_val = rf[d_rs1[AW-1:0]];
      if (WB_BYPASS && wb_id_wr_en && wb_id_rd_addr == d_rs1)
        rs1_val = wb_id_rd_data;
    end
  end

  always_comb begin
    rs2_val = '0;
    if (in_rf(d_rs2)) begin
      rs2_val = rf[d_rs2[AW-1:0]];
      if (WB_BYPASS && wb_id_wr_en && wb_id_rd_addr == d_rs2)
        rs2_val = wb_id_rd_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++)
        if (wb_id_wr_en && wb_id_rd_addr == 5'(i))
          rf[i] <= wb_id_rd_data;
    end
  end

  assign hazard = LOAD_USE_STALL && q.valid && is_load(q.instr_type) &&
                  q.write_en && (q.rd_addr != 5'd0) &&
                  ((q.rd_addr == d_rs1) || (q.rd_addr == d_rs2));

  assign advance     = !q.valid || id_ex_ready;
  assign if_id_ready = flush || (!halted && !hazard && advance);
  assign accept      = if_id_valid && if_id_ready && !flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q            <= '0;
      q.instr_type <= INSTR_NOP;
      halted       <= 1'b0;
      hazard_cnt   <= '0;
    end else if (flush) begin
      q.valid      <= 1'b0;
      q.instr_type <= INSTR_NOP;
      q.write_en   <= 1'b0;
      halted       <= 1'b0;
    end else if (accept) begin
      q.valid      <= 1'b1;
      q.instr_type <= d_type;
      q.rs1_addr   <= d_rs1;
      q.rs2_addr   <= d_rs2;
      q.rs1_data   <= rs1_val;
      q.rs2_data   <= rs2_val;
      q.imm        <= d_imm;
      q.pc         <= if_id_pc;
      q.rd_addr    <= d_rd;
      q.write_en   <= d_we;
      if (d_stall) halted <= 1'b1;
    end else if (advance) begin
      q.valid      <= 1'b0;
      q.instr_type <= INSTR_NOP;
      q.write_en   <= 1'b0;
      if (hazard && hazard_cnt != '1)
        hazard_cnt <= hazard_cnt + 1'b1;
    end
  end

  assign id_ex_valid      = q.valid;
  assign id_ex_instr_type = q.instr_type;
  assign id_ex_rs1_addr   = q.rs1_addr;
  assign id_ex_rs2_addr   = q.rs2_addr;
  assign id_ex_rs1_data   = q.rs1_data;
  assign id_ex_rs2_data   = q.rs2_data;
  assign id_ex_imm        = q.imm;
  assign id_ex_pc         = q.pc;
  assign id_ex_rd_addr    = q.rd_addr;
  assign id_ex_write_en   = q.write_en;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed bench for decode_issue_stage: RV32I/bypass instance plus an
// RV32E/no-bypass instance sharing the same stimulus.
module tb_decode_issue_stage;
  import rv32i_pkg::*;

  logic        clk, rst, flush;
  logic        if_id_valid;
  logic [31:0] if_id_instr_data, if_id_pc;
  logic        wb_id_wr_en;
  logic [4:0]  wb_id_rd_addr;
  logic [31:0] wb_id_rd_data;
  logic        id_ex_ready;

  logic         a_ready, a_valid, a_we, a_halted;
  rv32i_instr_e a_type;
  logic [4:0]   a_rs1a, a_rs2a, a_rd;
  logic [31:0]  a_rs1d, a_rs2d, a_imm, a_pc;
  logic [15:0]  a_cnt;

  logic         b_ready, b_valid, b_we, b_halted;
  rv32i_instr_e b_type;
  logic [4:0]   b_rs1a, b_rs2a, b_rd;
  logic [31:0]  b_rs1d, b_rs2d, b_imm, b_pc;
  logic [15:0]  b_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [31:0] ADDI1  = 32'h00500093;
  localparam logic [31:0] ADDI2  = 32'h00308113;
  localparam logic [31:0] LW5    = 32'h0000A283;
  localparam logic [31:0] ADD6   = 32'h00228333;
  localparam logic [31:0] ADD4   = 32'h00018233;
  localparam logic [31:0] ADD7   = 32'h000A03B3;
  localparam logic [31:0] ADD8   = 32'h00000433;
  localparam logic [31:0] ECALL  = 32'h00000073;

  decode_issue_stage dut_a (
    .clk(clk), .rst(rst), .flush(flush),
    .if_id_valid(if_id_valid), .if_id_ready(a_ready),
    .if_id_instr_data(if_id_instr_data), .if_id_pc(if_id_pc),
    .wb_id_wr_en(wb_id_wr_en), .wb_id_rd_addr(wb_id_rd_addr),
    .wb_id_rd_data(wb_id_rd_data),
    .id_ex_valid(a_valid), .id_ex_ready(id_ex_ready),
    .id_ex_instr_type(a_type),
    .id_ex_rs1_addr(a_rs1a), .id_ex_rs2_addr(a_rs2a),
    .id_ex_rs1_data(a_rs1d), .id_ex_rs2_data(a_rs2d),
    .id_ex_imm(a_imm), .id_ex_pc(a_pc),
    .id_ex_rd_addr(a_rd), .id_ex_write_en(a_we),
    .halted(a_halted), .hazard_cnt(a_cnt)
  );

  decode_issue_stage #(.NUM_REGS(16), .WB_BYPASS(1'b0)) dut_b (
    .clk(clk), .rst(rst), .flush(flush),
    .if_id_valid(if_id_valid), .if_id_ready(b_ready),
    .if_id_instr_data(if_id_instr_data), .if_id_pc(if_id_pc),
    .wb_id_wr_en(wb_id_wr_en), .wb_id_rd_addr(wb_id_rd_addr),
    .wb_id_rd_data(wb_id_rd_data),
    .id_ex_valid(b_valid), .id_ex_ready(id_ex_ready),
    .id_ex_instr_type(b_type),
    .id_ex_rs1_addr(b_rs1a), .id_ex_rs2_addr(b_rs2a),
    .id_ex_rs1_data(b_rs1d), .id_ex_rs2_data(b_rs2d),
    .id_ex_imm(b_imm), .id_ex_pc(b_pc),
    .id_ex_rd_addr(b_rd), .id_ex_write_en(b_we),
    .halted(b_halted), .hazard_cnt(b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
    if_id_valid      = 1'b1;
    if_id_instr_data = ins;
    if_id_pc         = pc;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    if_id_valid = 1'b0; if_id_instr_data = '0; if_id_pc = '0;
    wb_id_wr_en = 1'b0; wb_id_rd_addr = '0; wb_id_rd_data = '0;
    id_ex_ready = 1'b1;
    #2 rst = 1'b0;
    tick();
    chk("rst_valid", 32'(a_valid), 32'd0);
    chk("rst_type", 32'(a_type), 32'(INSTR_NOP));
    chk("rst_pc", a_pc, 32'd0);
    chk("rst_halted", 32'(a_halted), 32'd0);
    chk("rst_cnt", 32'(a_cnt), 32'd0);
    rst = 1'b1;
    #1 chk("rst_ready", 32'(a_ready), 32'd1);

    // back-to-back stream
    tick();
    issue(ADDI1, 32'h100);
    tick();
    chk("s1_valid", 32'(a_valid), 32'd1);
    chk("s1_imm", a_imm, 32'd5);
    chk("s1_rd", 32'(a_rd), 32'd1);
    chk("s1_type", 32'(a_type), 32'(INSTR_OPIMM));
    chk("s1_pc", a_pc, 32'h100);
    issue(ADDI2, 32'h104);
    #1 chk("s2_ready", 32'(a_ready), 32'd1);
    tick();
    chk("s2_valid", 32'(a_valid), 32'd1);
    chk("s2_imm", a_imm, 32'd3);
    chk("s2_rs1a", 32'(a_rs1a), 32'd1);
    chk("s2_cnt", 32'(a_cnt), 32'd0);

    // load-use
    issue(LW5, 32'h108);
    tick();
    chk("lw_type", 32'(a_type), 32'(INSTR_LW));
    issue(ADD6, 32'h10C);
    #1 chk("lu_ready", 32'(a_ready), 32'd0);
    tick();
    chk("lu_bubble", 32'(a_valid), 32'd0);
    chk("lu_cnt", 32'(a_cnt), 32'd1);
    chk("lu_ready2", 32'(a_ready), 32'd1);
    tick();
    chk("lu_issue", 32'(a_valid), 32'd1);
    chk("lu_pc", a_pc, 32'h10C);
    chk("lu_type", 32'(a_type), 32'(INSTR_OP));
    chk("lu_cnt2", 32'(a_cnt), 32'd1);

    // writeback in same cycle as read
    issue(ADD4, 32'h110);
    wb_id_wr_en = 1'b1; wb_id_rd_addr = 5'd3;
    wb_id_rd_data = 32'hDEADBEEF;
    tick();
    wb_id_wr_en = 1'b0;
    chk("byp_on", a_rs1d, 32'hDEADBEEF);
    chk("byp_off", b_rs1d, 32'd0);
    chk("byp_rs1a", 32'(a_rs1a), 32'd3);
    issue(ADD4, 32'h114);
    tick();
    chk("wb_vis_b", b_rs1d, 32'hDEADBEEF);

    // RV32E range and x0
    if_id_valid = 1'b0;
    wb_id_wr_en = 1'b1; wb_id_rd_addr = 5'd20; wb_id_rd_data = 32'd7;
    tick();
    wb_id_rd_addr = 5'd0; wb_id_rd_data = 32'd9;
    tick();
    wb_id_wr_en = 1'b0;
    issue(ADD7, 32'h118);
    tick();
    chk("x20_rv32i", a_rs1d, 32'd7);
    chk("x20_rv32e", b_rs1d, 32'd0);
    chk("x20_addr_e", 32'(b_rs1a), 32'd20);
    issue(ADD8, 32'h11C);
    tick();
    chk("x0_a", a_rs1d, 32'd0);
    chk("x0_b", b_rs2d, 32'd0);

    // backpressure
    id_ex_ready = 1'b0;
    issue(ADDI1, 32'h120);
    #1 chk("bp_ready", 32'(a_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_valid", 32'(a_valid), 32'd1);
      chk("bp_pc", a_pc, 32'h11C);
      chk("bp_rd", 32'(a_rd), 32'd8);
      chk("bp_ready_h", 32'(a_ready), 32'd0);
    end
    id_ex_ready = 1'b1;
    #1 chk("bp_rel", 32'(a_ready), 32'd1);
    tick();
    chk("bp_pc2", a_pc, 32'h120);
    chk("bp_imm2", a_imm, 32'd5);

    // halt then flush (flush also drops the presented instruction)
    issue(ECALL, 32'h124);
    tick();
    chk("h_halted", 32'(a_halted), 32'd1);
    chk("h_type", 32'(a_type), 32'(INSTR_SYSTEM));
    issue(ADDI1, 32'h128);
    #1 chk("h_ready", 32'(a_ready), 32'd0);
    tick();
    chk("h_bubble", 32'(a_valid), 32'd0);
    chk("h_still", 32'(a_halted), 32'd1);
    tick();
    chk("h_ready2", 32'(a_ready), 32'd0);
    flush = 1'b1;
    #1 chk("f_ready", 32'(a_ready), 32'd1);
    tick();
    flush = 1'b0;
    chk("f_halted", 32'(a_halted), 32'd0);
    chk("f_valid", 32'(a_valid), 32'd0);
    chk("f_pc_hold", a_pc, 32'h124);

    // flush wins over hazard
    issue(LW5, 32'h204);
    tick();
    chk("fh_lw", 32'(a_valid), 32'd1);
    issue(ADD6, 32'h208);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    if_id_valid = 1'b0;
    chk("fh_valid", 32'(a_valid), 32'd0);
    chk("fh_cnt", 32'(a_cnt), 32'd1);

    // reset mid-stall
    issue(LW5, 32'h20C);
    tick();
    issue(ADD6, 32'h210);
    #1 chk("rs_ready", 32'(a_ready), 32'd0);
    chk("rs_cnt_pre", 32'(a_cnt), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("rs_valid", 32'(a_valid), 32'd0);
    chk("rs_pc", a_pc, 32'd0);
    chk("rs_cnt", 32'(a_cnt), 32'd0);
    chk("rs_type", 32'(a_type), 32'(INSTR_NOP));
    chk("rs_ready2", 32'(a_ready), 32'd1);
    if_id_valid = 1'b0;
    #1 rst = 1'b1;
    issue(ADD4, 32'h300);
    tick();
    chk("rs_rf_clr", a_rs1d, 32'd0);
    chk("rs_pc2", a_pc, 32'h300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
